dac_playback_src: RTL and testbench

AXI4-Stream master that plays a stored waveform into the RF DAC sample stream (the transmit-side counterpart of the ADC capture path). Waveform words of eight 16-bit samples are loaded through a 32-bit lane write port into an internal block RAM. Playback is armed, then started by a trigger, and runs once or loops. Sits in the aclk domain between the control register bank and the DAC AXI4-Stream input.

---
 rtl/dac_playback_src.sv | 167 ++++++++++++++++
 tb/tb_dac_playback_src.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_playback_src.sv
// Waveform playback source: a lane-writable RAM that is streamed out as AXI4-Stream.
// It plays one pass or loops, with a 2-entry skid buffer so backpressure never drops a beat.
module dac_playback_src #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 128,
  parameter int LANES      = DATA_WIDTH / 32,
  parameter int LANE_BITS  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  mem_we,
  input  logic [ADDR_BITS-1:0]  mem_addr,
  input  logic [LANE_BITS-1:0]  mem_lane,
  input  logic [31:0]           mem_wdata,
  input  logic [ADDR_BITS:0]    play_len,
  input  logic                  loop,
  input  logic                  arm,
  input  logic                  trig_in,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [1:0]            state,
  output logic                  done,
  output logic [15:0]           loop_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  localparam logic [ADDR_BITS:0] ONE     = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0] MAX_LEN = {1'b1, {ADDR_BITS{1'b0}}};

  logic [DATA_WIDTH-1:0] ram [0:(1<<ADDR_BITS)-1];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] e0;
  logic [DATA_WIDTH-1:0] e1;
  logic                  l0;
  logic                  l1;
  logic [1:0]            cnt;
  logic [1:0]            cnt_ap;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  rd_done;
  logic                  loop_q;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [ADDR_BITS:0]    len_q;
  logic [2:0]            occ;
  logic                  pop;
  logic                  rd_en;
  logic                  is_last;
  logic                  arm_ok;
  logic                  last_acc;

  assign arm_ok        = arm && (play_len != '0) && (play_len <= MAX_LEN);
  assign m_axis_tvalid = (cnt != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? e0 : '0;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign cnt_ap        = cnt - {1'b0, pop};
  // Slots still owed after this cycle: buffered + in-flight read - pop.
  assign occ     = {1'b0, cnt} + {2'b0, rd_valid} - {2'b0, pop};
  assign is_last = ({1'b0, rd_ptr} == (len_q - ONE));
  assign rd_en   = (state == S_PLAY) && !stop && !rd_done && (occ <= 3'd1);
  assign last_acc = (state == S_PLAY) && pop && l0;
  assign done    = last_acc && !loop_q && !stop && !arst;

  always_ff @(posedge aclk) begin
    if (mem_we)
      ram[mem_addr][{mem_lane, 5'b0} +: 32] <= mem_wdata;
    if (rd_en)
      rd_data <= ram[rd_ptr];
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      e0         <= '0;
      e1         <= '0;
      l0         <= 1'b0;
      l1         <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_done    <= 1'b0;
      rd_ptr     <= '0;
      len_q      <= ONE;
      loop_q     <= 1'b0;
      loop_count <= 16'd0;
    end else begin
      if (pop && cnt == 2'd2) begin
        e0 <= e1;
        l0 <= l1;
      end
      if (rd_valid) begin
        if (cnt_ap == 2'd0) begin
          e0 <= rd_data;
          l0 <= rd_last;
        end else begin
          e1 <= rd_data;
          l1 <= rd_last;
        end
      end
      cnt      <= cnt_ap + {1'b0, rd_valid};
      rd_valid <= rd_en;
      rd_last  <= is_last;
      if (rd_en) begin
        if (is_last) begin
          rd_ptr <= '0;
          if (!loop_q)
            rd_done <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      if (last_acc && loop_count != 16'hFFFF)
        loop_count <= loop_count + 16'd1;
      unique case (state)
        S_IDLE: begin
          if (arm_ok) begin
            state      <= S_ARMED;
            len_q      <= play_len;
            loop_q     <= loop;
            loop_count <= 16'd0;
          end
        end
        S_ARMED: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (trig_in) begin
            state   <= S_PLAY;
            rd_ptr  <= '0;
            rd_done <= 1'b0;
          end else if (arm_ok) begin
            len_q      <= play_len;
            loop_q     <= loop;
            loop_count <= 16'd0;
          end
        end
        S_PLAY: begin
          if (stop) begin
            // Keep only the beat already on the bus; drop everything behind it.
            rd_valid <= 1'b0;
            if (m_axis_tvalid && !m_axis_tready) begin
              state <= S_STOP;
              cnt   <= 2'd1;
            end else begin
              state <= S_IDLE;
              cnt   <= 2'd0;
            end
          end else if (last_acc && !loop_q) begin
            state <= S_IDLE;
          end
        end
        S_STOP: begin
          rd_valid <= 1'b0;
          if (pop) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_playback_src.sv
// Directed bench for dac_playback_src: single pass, looping, backpressure,
// stop, arm corner cases and reset during playback.
module tb_dac_playback_src;

  logic         aclk = 1'b0;
  logic         arst;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [1:0]   mem_lane;
  logic [31:0]  mem_wdata;
  logic [10:0]  play_len;
  logic         loop;
  logic         arm;
  logic         trig_in;
  logic         stop;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [1:0]   state;
  logic         done;
  logic [15:0]  loop_count;

  int n_checks = 0;
  int n_err    = 0;

  always #5 aclk = ~aclk;

  dac_playback_src dut (
    .aclk          (aclk),
    .arst          (arst),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_lane      (mem_lane),
    .mem_wdata     (mem_wdata),
    .play_len      (play_len),
    .loop          (loop),
    .arm           (arm),
    .trig_in       (trig_in),
    .stop          (stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .state         (state),
    .done          (done),
    .loop_count    (loop_count)
  );

  function automatic logic [127:0] wv(int n);
    logic [15:0] s;
    s = 16'(n);
    return {8{s}};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic load_words();
    for (int w = 0; w < 4; w++) begin
      for (int l = 0; l < 4; l++) begin
        mem_we    = 1'b1;
        mem_addr  = 10'(w);
        mem_lane  = 2'(l);
        mem_wdata = {2{16'(w)}};
        tick();
      end
    end
    mem_we = 1'b0;
  endtask

  task automatic arm_trig(input logic [10:0] len, input logic lp);
    play_len = len;
    loop     = lp;
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
    trig_in  = 1'b1;
    tick();
    trig_in  = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
    n_checks++;
    if (state !== 2'd0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 ||
        done !== 1'b0 || loop_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset: state=%0d tvalid=%b tdata=%h done=%b lc=%0d, want 0/0/0/0/0",
               state, m_axis_tvalid, m_axis_tdata, done, loop_count);
    end
  endtask

  task automatic test_single_pass();
    m_axis_tready = 1'b1;
    play_len = 11'd4;
    loop     = 1'b0;
    arm      = 1'b1;
    tick();
    arm = 1'b0;
    n_checks++;
    if (state !== 2'd1) begin
      n_err++;
      $display("FAIL single_armed: state=%0d want 1", state);
    end
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    n_checks++;
    if (state !== 2'd2 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_trig: state=%0d tvalid=%b want 2/0", state, m_axis_tvalid);
    end
    tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: tvalid=%b want 0 one cycle after trig", m_axis_tvalid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== wv(k) || done !== (k == 3)) begin
        n_err++;
        $display("FAIL single_beat%0d: tvalid=%b tdata=%h done=%b want 1/%h/%b",
                 k, m_axis_tvalid, m_axis_tdata, done, wv(k), (k == 3));
      end
    end
    tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || state !== 2'd0 ||
        loop_count !== 16'd1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL single_end: tvalid=%b tdata=%h state=%0d lc=%0d done=%b want 0/0/0/1/0",
               m_axis_tvalid, m_axis_tdata, state, loop_count, done);
    end
  endtask

  task automatic test_loop();
    m_axis_tready = 1'b1;
    arm_trig(11'd3, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== wv(k % 3) || done !== 1'b0) begin
        n_err++;
        $display("FAIL loop_beat%0d: tvalid=%b tdata=%h done=%b want 1/%h/0",
                 k, m_axis_tvalid, m_axis_tdata, done, wv(k % 3));
      end
    end
    n_checks++;
    if (loop_count !== 16'd3) begin
      n_err++;
      $display("FAIL loop_count: got %0d want 3", loop_count);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (state !== 2'd0 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL loop_stop: state=%0d tvalid=%b want 0/0", state, m_axis_tvalid);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int cyc = 0;
    logic held_v = 1'b0;
    logic [127:0] held = '0;
    m_axis_tready = 1'b0;
    arm_trig(11'd3, 1'b1);
    while (acc < 200 && cyc < 3000) begin
      if (held_v) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin
          n_err++;
          $display("FAIL bp_stall: tvalid=%b tdata=%h want 1/%h",
                   m_axis_tvalid, m_axis_tdata, held);
        end
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (m_axis_tdata !== wv(acc % 3)) begin
          n_err++;
          $display("FAIL bp_beat%0d: tdata=%h want %h", acc, m_axis_tdata, wv(acc % 3));
        end
        acc++;
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held   = m_axis_tdata;
      tick();
      cyc++;
    end
    n_checks++;
    if (acc < 200) begin
      n_err++;
      $display("FAIL bp_timeout: accepted %0d want 200", acc);
    end
    m_axis_tready = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (state !== 2'd0 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stop: state=%0d tvalid=%b want 0/0", state, m_axis_tvalid);
    end
  endtask

  task automatic test_stop();
    m_axis_tready = 1'b0;
    arm_trig(11'd4, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== wv(0)) begin
      n_err++;
      $display("FAIL stop_pre: tvalid=%b tdata=%h want 1/%h", m_axis_tvalid, m_axis_tdata, wv(0));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (state !== 2'd3 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== wv(0) || done !== 1'b0) begin
        n_err++;
        $display("FAIL stop_hold%0d: state=%0d tvalid=%b tdata=%h done=%b want 3/1/%h/0",
                 i, state, m_axis_tvalid, m_axis_tdata, done, wv(0));
      end
      tick();
    end
    m_axis_tready = 1'b1;
    n_checks++;
    if (done !== 1'b0 || m_axis_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL stop_accept: done=%b tvalid=%b want 0/1", done, m_axis_tvalid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (state !== 2'd0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL stop_after%0d: state=%0d tvalid=%b tdata=%h done=%b want 0/0/0/0",
                 i, state, m_axis_tvalid, m_axis_tdata, done);
      end
      tick();
    end
  endtask

  task automatic test_arm_corners();
    m_axis_tready = 1'b1;
    play_len = 11'd0;
    arm      = 1'b1;
    tick();
    arm = 1'b0;
    n_checks++;
    if (state !== 2'd0) begin
      n_err++;
      $display("FAIL arm_len0: state=%0d want 0", state);
    end
    play_len = 11'd1025;
    arm      = 1'b1;
    tick();
    arm = 1'b0;
    n_checks++;
    if (state !== 2'd0) begin
      n_err++;
      $display("FAIL arm_len1025: state=%0d want 0", state);
    end
    play_len = 11'd2;
    loop     = 1'b0;
    arm      = 1'b1;
    trig_in  = 1'b1;
    tick();
    arm     = 1'b0;
    trig_in = 1'b0;
    tick();
    tick();
    n_checks++;
    if (state !== 2'd1 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL arm_trig_same: state=%0d tvalid=%b want 1/0", state, m_axis_tvalid);
    end
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== wv(k) || done !== (k == 1)) begin
        n_err++;
        $display("FAIL arm_play%0d: tvalid=%b tdata=%h done=%b want 1/%h/%b",
                 k, m_axis_tvalid, m_axis_tdata, done, wv(k), (k == 1));
      end
    end
    tick();
    n_checks++;
    if (state !== 2'd0 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL arm_end: state=%0d tvalid=%b want 0/0", state, m_axis_tvalid);
    end
  endtask

  task automatic test_reset_mid_play();
    m_axis_tready = 1'b1;
    arm_trig(11'd4, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) tick();
    n_checks++;
    if (loop_count !== 16'd1 || state !== 2'd2) begin
      n_err++;
      $display("FAIL rst_pre: lc=%0d state=%0d want 1/2", loop_count, state);
    end
    arst = 1'b1;
    tick();
    arst = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || state !== 2'd0 || loop_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid: tvalid=%b tdata=%h state=%0d lc=%0d want 0/0/0/0",
               m_axis_tvalid, m_axis_tdata, state, loop_count);
    end
    arm_trig(11'd4, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== wv(k)) begin
        n_err++;
        $display("FAIL rst_replay%0d: tvalid=%b tdata=%h want 1/%h",
                 k, m_axis_tvalid, m_axis_tdata, wv(k));
      end
    end
    tick();
    n_checks++;
    if (state !== 2'd0 || loop_count !== 16'd1) begin
      n_err++;
      $display("FAIL rst_replay_end: state=%0d lc=%0d want 0/1", state, loop_count);
    end
  endtask

  initial begin
    arst          = 1'b1;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_lane      = '0;
    mem_wdata     = '0;
    play_len      = '0;
    loop          = 1'b0;
    arm           = 1'b0;
    trig_in       = 1'b0;
    stop          = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    load_words();
    test_single_pass();
    test_loop();
    test_backpressure();
    test_stop();
    test_arm_corners();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
